// File: rtl/fetch_queue.sv
// swt16 fetch stage: PC-driven program-memory fetch feeding a 2-entry prefetch queue to decode.
// Optional bubble statistics counter is enabled by defining FETCH_BUBBLE_STATS_EN.
module fetch_queue #(
  parameter int PC_WIDTH        = 12,
  parameter int PC_INCREMENT    = 2,
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int RESET_PC        = 0,
  parameter int STAT_WIDTH      = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_set_pc,
  input  logic [PMEM_ADDR_WIDTH-1:0] in_branch_pc,
  input  logic                       in_flush_FE,
  input  logic                       in_stall,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_word,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  output logic                       out_pmem_rd,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_flush,
  output logic [STAT_WIDTH-1:0]      out_bubble_count
);

  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_INCREMENT);

  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic                       inflight_v_q, inflight_v_d;
  logic [PC_WIDTH-1:0]        inflight_pc_q, inflight_pc_d;
  logic [1:0]                 count_q, count_d;
  logic [PMEM_WORD_WIDTH-1:0] word0_q, word0_d, word1_q, word1_d;
  logic [PC_WIDTH-1:0]        pc0_q, pc0_d, pc1_q, pc1_d;

  logic                       pop, push, redirect, issue;
  logic [2:0]                 occupancy;
  logic [PC_WIDTH-1:0]        fetch_addr;

  assign out_flush = (count_q == 2'd0);
  assign pop       = !out_flush && !in_stall;
  assign redirect  = in_set_pc || in_flush_FE;
  assign push      = inflight_v_q && !redirect;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_v_q} - {2'b00, pop};
  assign issue     = redirect ? in_set_pc : (occupancy < 3'd2);

  assign fetch_addr    = in_set_pc ? PC_WIDTH'(in_branch_pc) : pc_q;
  // Reset gates the combinational fetch path so memory sees an idle reset-PC request.
  assign out_pmem_addr = reset ? PMEM_ADDR_WIDTH'(RST_PC) : PMEM_ADDR_WIDTH'(fetch_addr);
  assign out_pmem_rd   = !reset && issue;

  assign out_instr = out_flush ? '0 : word0_q;
  assign out_pc    = out_flush ? '0 : pc0_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_v_d  = issue;
    inflight_pc_d = fetch_addr;
    count_d       = count_q;
    word0_d       = word0_q;
    word1_d       = word1_q;
    pc0_d         = pc0_q;
    pc1_d         = pc1_q;

    if (issue) pc_d = fetch_addr + PC_INC;

    if (redirect) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b01: begin
          word0_d = word1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            word0_d = in_pmem_word;
            pc0_d   = inflight_pc_q;
          end else begin
            word1_d = in_pmem_word;
            pc1_d   = inflight_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            word0_d = in_pmem_word;
            pc0_d   = inflight_pc_q;
          end else begin
            word0_d = word1_q;
            pc0_d   = pc1_q;
            word1_d = in_pmem_word;
            pc1_d   = inflight_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RST_PC;
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      word0_q       <= '0;
      word1_q       <= '0;
      pc0_q         <= '0;
      pc1_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      word0_q       <= word0_d;
      word1_q       <= word1_d;
      pc0_q         <= pc0_d;
      pc1_q         <= pc1_d;
    end
  end

  // The issue rule reserves a slot for every in-flight word, so a full-queue push is a bug.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push && !pop && count_q == 2'd2))
        else $error("fetch_queue overflow");
    end
  end

`ifdef FETCH_BUBBLE_STATS_EN
  logic [STAT_WIDTH-1:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (out_flush && (bubble_q != {STAT_WIDTH{1'b1}})) bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) bubble_q <= '0;
    else       bubble_q <= bubble_d;
  end

  assign out_bubble_count = bubble_q;
`else
  assign out_bubble_count = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model returns word = address one cycle after issue.
// Bubble-count expectations follow FETCH_BUBBLE_STATS_EN.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_set_pc;
  logic [11:0] in_branch_pc;
  logic        in_flush_FE;
  logic        in_stall;
  logic [15:0] in_pmem_word;
  logic [11:0] out_pmem_addr;
  logic        out_pmem_rd;
  logic [15:0] out_instr;
  logic [11:0] out_pc;
  logic        out_flush;
  logic [15:0] out_bubble_count;

  int errors = 0;
  int checks = 0;

  fetch_queue dut (
    .clock            (clock),
    .reset            (reset),
    .in_set_pc        (in_set_pc),
    .in_branch_pc     (in_branch_pc),
    .in_flush_FE      (in_flush_FE),
    .in_stall         (in_stall),
    .in_pmem_word     (in_pmem_word),
    .out_pmem_addr    (out_pmem_addr),
    .out_pmem_rd      (out_pmem_rd),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .out_flush        (out_flush),
    .out_bubble_count (out_bubble_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) in_pmem_word <= {4'h0, out_pmem_addr};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cy(input logic sp, input logic fl, input logic [11:0] br, input logic st);
    @(posedge clock);
    #1;
    in_set_pc    = sp;
    in_flush_FE  = fl;
    in_branch_pc = br;
    in_stall     = st;
    #1;
  endtask

  task automatic ex(input string tag, input logic fl, input logic [11:0] pc,
                    input logic rd, input logic [11:0] addr);
    chk({tag, ".flush"}, 32'(out_flush), 32'(fl));
    if (!fl) begin
      chk({tag, ".pc"}, 32'(out_pc), 32'(pc));
      chk({tag, ".instr"}, 32'(out_instr), {20'h0, pc});
    end
    chk({tag, ".rd"}, 32'(out_pmem_rd), 32'(rd));
    chk({tag, ".addr"}, 32'(out_pmem_addr), 32'(addr));
  endtask

  task automatic ex_reset(input string tag);
    chk({tag, ".flush"}, 32'(out_flush), 32'd1);
    chk({tag, ".instr"}, 32'(out_instr), 32'd0);
    chk({tag, ".pc"}, 32'(out_pc), 32'd0);
    chk({tag, ".rd"}, 32'(out_pmem_rd), 32'd0);
    chk({tag, ".addr"}, 32'(out_pmem_addr), 32'd0);
    chk({tag, ".bubbles"}, 32'(out_bubble_count), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    in_set_pc    = 1'b0;
    in_flush_FE  = 1'b0;
    in_branch_pc = 12'h000;
    in_stall     = 1'b0;
    #2;
    ex_reset("rst");
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;

    // sequential fetch from reset
    ex("a0", 1, 12'h000, 1, 12'h000);
    cy(0, 0, 0, 0); ex("a1", 1, 12'h000, 1, 12'h002);
    cy(0, 0, 0, 0); ex("a2", 0, 12'h000, 1, 12'h004);
    cy(0, 0, 0, 0); ex("a3", 0, 12'h002, 1, 12'h006);

    // stall with head 0x004: 0x006 is already in flight, queue fills, no further issue
    for (int i = 0; i < 5; i++) begin
      cy(0, 0, 0, 1); ex($sformatf("s%0d", i), 0, 12'h004, 0, 12'h008);
    end
    cy(0, 0, 0, 0); ex("r0", 0, 12'h004, 1, 12'h008);
    cy(0, 0, 0, 0); ex("r1", 0, 12'h006, 1, 12'h00A);
    cy(0, 0, 0, 0); ex("r2", 0, 12'h008, 1, 12'h00C);

    // fill queue, then redirect + flush to 0x100
    cy(0, 0, 0, 1); ex("r3", 0, 12'h00A, 0, 12'h00E);
    cy(0, 0, 0, 1); ex("r4", 0, 12'h00A, 0, 12'h00E);
    cy(1, 1, 12'h100, 0); ex("br0", 0, 12'h00A, 1, 12'h100);
    cy(0, 0, 0, 0); ex("br1", 1, 12'h000, 1, 12'h102);
    cy(0, 0, 0, 0); ex("br2", 0, 12'h100, 1, 12'h104);
    cy(0, 0, 0, 0); ex("br3", 0, 12'h102, 1, 12'h106);

    // set_pc alone behaves as a flushing redirect
    cy(1, 0, 12'h00C, 0); ex("sp0", 0, 12'h104, 1, 12'h00C);
    cy(0, 0, 0, 0); ex("sp1", 1, 12'h000, 1, 12'h00E);

    // flush alone at pc_ff=0x010: 0x00E is dropped and fetch resumes at 0x010
    cy(0, 1, 0, 0); ex("fl0", 0, 12'h00C, 0, 12'h010);
    cy(0, 0, 0, 0); ex("fl1", 1, 12'h000, 1, 12'h010);
    cy(0, 0, 0, 0); ex("fl2", 1, 12'h000, 1, 12'h012);
    cy(0, 0, 0, 0); ex("fl3", 0, 12'h010, 1, 12'h014);
    cy(0, 0, 0, 0); ex("fl4", 0, 12'h012, 1, 12'h016);

    // wrap past the top of the address space
    cy(1, 1, 12'hFFC, 0); ex("w0", 0, 12'h014, 1, 12'hFFC);
    cy(0, 0, 0, 0); ex("w1", 1, 12'h000, 1, 12'hFFE);
    cy(0, 0, 0, 0); ex("w2", 0, 12'hFFC, 1, 12'h000);
    cy(0, 0, 0, 0); ex("w3", 0, 12'hFFE, 1, 12'h002);
    cy(0, 0, 0, 0); ex("w4", 0, 12'h000, 1, 12'h004);
    cy(0, 0, 0, 0); ex("w5", 0, 12'h002, 1, 12'h006);

    // reset mid-stream with a full queue
    cy(0, 0, 0, 1); ex("q0", 0, 12'h004, 0, 12'h008);
    cy(0, 0, 0, 1); ex("q1", 0, 12'h004, 0, 12'h008);
    @(posedge clock);
    #1 reset = 1'b1; in_stall = 1'b0;
    #1 ex_reset("mrst");
    @(posedge clock);
    #1 reset = 1'b0;
    #1 ex("t0", 1, 12'h000, 1, 12'h000);
    cy(0, 0, 0, 0); ex("t1", 1, 12'h000, 1, 12'h002);
    cy(0, 0, 0, 0); ex("t2", 0, 12'h000, 1, 12'h004);
`ifdef FETCH_BUBBLE_STATS_EN
    chk("t2.bubbles", 32'(out_bubble_count), 32'd2);
`else
    chk("t2.bubbles", 32'(out_bubble_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
